// File: rtl/serial_addsub.sv
// rtl/serial_addsub.sv - bit-serial WIDTH-bit adder/subtractor built on one FAS cell
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]       r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_res_sh;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sub;
  logic             r_carry;
  logic             r_done;
  logic [WIDTH-1:0] r_result;
  logic             r_cout;
  logic             r_ovf;

  logic             w_fas_a;
  logic             w_fas_s;
  logic             w_fas_cout;
  logic [WIDTH-1:0] w_res_next;

  // FAS cell: A is inverted for subtract; the +1 comes from the carry preload
  assign w_fas_a    = r_a_sh[0] ^ r_sub;
  assign w_fas_s    = w_fas_a ^ r_b_sh[0] ^ r_carry;
  assign w_fas_cout = (w_fas_a & r_b_sh[0]) | (w_fas_a & r_carry) | (r_b_sh[0] & r_carry);
  assign w_res_next = {w_fas_s, r_res_sh[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_res_sh <= '0;
      r_cnt    <= '0;
      r_sub    <= 1'b0;
      r_carry  <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == IDLE) begin
        if (start) begin
          r_a_sh  <= a;
          r_b_sh  <= b;
          r_sub   <= sub;
          r_carry <= sub;
          r_cnt   <= '0;
          r_state <= RUN;
        end
      end else begin
        r_res_sh <= w_res_next;
        r_carry  <= w_fas_cout;
        r_a_sh   <= r_a_sh >> 1;
        r_b_sh   <= r_b_sh >> 1;
        r_cnt    <= r_cnt + 1'b1;
        // r_carry here is the carry into the MSB, so xor with Cout flags signed overflow
        if (r_cnt == LAST_BIT) begin
          r_result <= w_res_next;
          r_cout   <= w_fas_cout;
          r_ovf    <= r_carry ^ w_fas_cout;
          r_done   <= 1'b1;
          r_state  <= IDLE;
        end
      end
    end
  end

  assign busy     = (r_state == RUN);
  assign done     = r_done;
  assign result   = r_result;
  assign cout     = r_cout;
  assign overflow = r_ovf;

endmodule

// File: doc/serial_addsub.md
# serial_addsub

Bit-serial WIDTH-bit adder/subtractor sequencer built around a single FAS cell (one-bit full adder/subtractor: sum = (A xor con) + B + Cin). It captures two operands on a start strobe and feeds them to the FAS cell LSB-first, one bit per clock. A carry flip-flop closes the loop from Cout back to Cin. It assembles the result, then reports completion, carry and signed overflow. It trades WIDTH cycles of latency for one FAS instance in place of a WIDTH-bit ripple chain.

## Interface
- WIDTH, 8, operand/result width in bits; legal range WIDTH >= 2
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only when busy=0
- sub  in  1  0: result = b + a; 1: result = b - a (drives FAS con)
- a  in  WIDTH  operand routed to FAS A input (inverted when sub=1)
- b  in  WIDTH  operand routed to FAS B input
- busy  out  1  high while an operation is in progress
- done  out  1  one-cycle pulse; result/cout/overflow valid from this cycle on
- result  out  WIDTH  sum or difference, modulo 2^WIDTH
- cout  out  1  final carry; for sub, 1 = no borrow (b >= a unsigned)
- overflow  out  1  two's-complement overflow of the operation

## Operation
- States: IDLE, RUN. done is a registered pulse, not a state.
- IDLE, start=1: latch a, b and sub into shift registers.
  - Set carry <= sub, so subtract forms b + ~a + 1.
  - Clear bit counter to 0, set busy <= 1, move to RUN.
- RUN, each edge:
  - FAS inputs: A = a_sh[0], B = b_sh[0], con = sub_q, Cin = carry.
  - Shift S into res_sh from the MSB end.
  - carry <= Cout; shift a_sh and b_sh right by 1; counter += 1.
- RUN, on the edge where counter = WIDTH-1 (last bit):
  - Write the completed res_sh to result.
  - cout <= Cout.
  - overflow <= carry (carry into MSB) xor Cout.
  - Set busy <= 0, done <= 1, return to IDLE.
- start while busy=1 is ignored; it is not queued, and operands and sub are not resampled.
- a, b and sub may change freely after the capture edge.
- result, cout and overflow hold their values until the next completion; they do not change at start.
- The counter width is clog2(WIDTH); no wrap occurs because RUN exits at WIDTH-1.

## Timing
- Reset (rst_n=0, asynchronous): state IDLE, busy=0, done=0, result=0, cout=0, overflow=0; internal shift registers, counter and carry = 0.
- Reset asserted during RUN aborts the operation immediately, with no done pulse.
- Deassertion of reset takes effect at the first rising edge with rst_n=1.
- Let edge E0 be the edge that samples start=1 in IDLE.
  - busy is high from after E0 through the edge E_WIDTH.
  - Edges E1..E_WIDTH each process one bit.
  - done is high for exactly the one cycle after E_WIDTH.
  - Latency from start sample to done is WIDTH+1 edges.
- Throughput: start may be asserted in the done cycle; it is accepted because busy=0. Back-to-back operations therefore take WIDTH+1 cycles each.
- done and busy are never high in the same cycle.

## Test plan
- Add, WIDTH=8, sub=0, a=0x05, b=0x3C, start for 1 cycle:
  - busy high for 8 cycles, then done pulses for 1 cycle, 9 edges after the start sample.
  - result=0x41, cout=0, overflow=0.
- Subtract negative result, sub=1, a=0x05, b=0x03: result=0xFE, cout=0 (borrow), overflow=0.
- Signed overflow:
  - Add a=0x01, b=0x7F: result=0x80, cout=0, overflow=1.
  - Subtract a=0x01, b=0x80: result=0x7F, cout=1, overflow=1.
- Unsigned wrap, add a=0x01, b=0xFF: result=0x00, cout=1, overflow=0. Outputs hold these values for 20 idle cycles.
- Ignored start, back-to-back and reset:
  - Pulse start again mid-RUN with different a/b: ignored, and the first result is still correct.
  - Assert start in the done cycle: the second operation starts and completes 9 edges later.
  - Assert rst_n=0 mid-RUN: busy, done and result go to 0 asynchronously, with no done pulse.
